// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_pkg
// Description : Shared CPU definitions used by RS, ROB, LSB and the CDB
//               arbiter: datapath widths, the reserved "no tag" ROB value and
//               the grant encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

  localparam int CPU_DATA_W   = 32;
  localparam int CPU_ROB_ID_W = 5;
  // ROB tag 0 never names a real entry; a result carrying it is discarded.
  localparam int ROB_TAG_NONE = 0;

  // Which source owned the most recent CDB grant.
  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

endpackage : cdb_arbiter_pkg
`default_nettype wire

// File: rtl/cdb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cdb_fifo
// Description : Small per-source result queue feeding the CDB arbiter.
//               Push is ignored when full, pop is ignored when empty, and a
//               flush empties the queue. Head entry is shown combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_fifo #(
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = 5,
  parameter int DEPTH    = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     clr_in,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic [ROB_ID_W-1:0]      push_tag_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic [DATA_W-1:0]        head_data_o,
  output logic [ROB_ID_W-1:0]      head_tag_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [ROB_ID_W-1:0] tag_q  [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign w_push  = push_i & ~w_full & ~clr_in;
  assign w_pop   = pop_i & ~empty_o & ~clr_in;

  assign count_o     = count_q;
  assign head_data_o = data_q[rd_ptr_q];
  assign head_tag_o  = tag_q[rd_ptr_q];

  // Pointer/count next state; a flush overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      data_q[wr_ptr_q] <= push_data_i;
      tag_q[wr_ptr_q]  <= push_tag_i;
    end
  end

endmodule : cdb_fifo
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Common data bus arbiter. Queues ALU and LSU results, grants
//               one head per cycle (round-robin on contention) and broadcasts
//               it through registered cdb_* outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_W     = CPU_DATA_W,
  parameter int ROB_ID_W   = CPU_ROB_ID_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clr_in,
  input  logic                valid_from_alu,
  input  logic [DATA_W-1:0]   result_from_alu,
  input  logic [ROB_ID_W-1:0] rob_id_from_alu,
  input  logic                valid_from_lsu,
  input  logic [DATA_W-1:0]   result_from_lsu,
  input  logic [ROB_ID_W-1:0] rob_id_from_lsu,
  output logic                ready_to_alu,
  output logic                ready_to_lsu,
  output logic                cdb_valid,
  output logic [DATA_W-1:0]   cdb_result,
  output logic [ROB_ID_W-1:0] cdb_rob_id
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [CNT_W-1:0]    w_alu_count, w_lsu_count;
  logic                w_alu_empty, w_lsu_empty;
  logic [DATA_W-1:0]   w_alu_head_data, w_lsu_head_data;
  logic [ROB_ID_W-1:0] w_alu_head_tag, w_lsu_head_tag;

  logic w_run;
  logic w_alu_push, w_lsu_push;
  logic w_grant_alu, w_grant_lsu;

  grant_e              last_grant_q, last_grant_d;
  logic                cdb_valid_q, cdb_valid_d;
  logic [DATA_W-1:0]   cdb_result_q, cdb_result_d;
  logic [ROB_ID_W-1:0] cdb_rob_id_q, cdb_rob_id_d;

  // Normal operation only when enabled and not flushing.
  assign w_run = rdy_in & ~clr_in;

  // Ready comes purely from registered occupancy, so a full queue never
  // accepts on the same edge it is being popped.
  assign ready_to_alu = (w_alu_count < CNT_W'(FIFO_DEPTH));
  assign ready_to_lsu = (w_lsu_count < CNT_W'(FIFO_DEPTH));

  // A result carrying the reserved tag is silently dropped.
  assign w_alu_push = w_run & valid_from_alu & ready_to_alu &
                      (rob_id_from_alu != ROB_ID_W'(ROB_TAG_NONE));
  assign w_lsu_push = w_run & valid_from_lsu & ready_to_lsu &
                      (rob_id_from_lsu != ROB_ID_W'(ROB_TAG_NONE));

  cdb_fifo #(
    .DATA_W   (DATA_W),
    .ROB_ID_W (ROB_ID_W),
    .DEPTH    (FIFO_DEPTH)
  ) u_alu_fifo (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clr_in      (clr_in),
    .push_i      (w_alu_push),
    .push_data_i (result_from_alu),
    .push_tag_i  (rob_id_from_alu),
    .pop_i       (w_grant_alu),
    .count_o     (w_alu_count),
    .empty_o     (w_alu_empty),
    .head_data_o (w_alu_head_data),
    .head_tag_o  (w_alu_head_tag)
  );

  cdb_fifo #(
    .DATA_W   (DATA_W),
    .ROB_ID_W (ROB_ID_W),
    .DEPTH    (FIFO_DEPTH)
  ) u_lsu_fifo (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clr_in      (clr_in),
    .push_i      (w_lsu_push),
    .push_data_i (result_from_lsu),
    .push_tag_i  (rob_id_from_lsu),
    .pop_i       (w_grant_lsu),
    .count_o     (w_lsu_count),
    .empty_o     (w_lsu_empty),
    .head_data_o (w_lsu_head_data),
    .head_tag_o  (w_lsu_head_tag)
  );

  // Grant selection: contention goes to the source not granted last time,
  // a lone non-empty source always wins.
  always_comb begin
    w_grant_alu = 1'b0;
    w_grant_lsu = 1'b0;
    if (w_run) begin
      if (!w_alu_empty && !w_lsu_empty) begin
        if (last_grant_q == GRANT_LSU) w_grant_alu = 1'b1;
        else                           w_grant_lsu = 1'b1;
      end else if (!w_alu_empty) begin
        w_grant_alu = 1'b1;
      end else if (!w_lsu_empty) begin
        w_grant_lsu = 1'b1;
      end
    end
  end

  // Broadcast/last-grant next state: flush kills the pulse, stall holds all.
  always_comb begin
    last_grant_d = last_grant_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_result_d = cdb_result_q;
    cdb_rob_id_d = cdb_rob_id_q;
    if (clr_in) begin
      cdb_valid_d = 1'b0;
    end else if (rdy_in) begin
      cdb_valid_d = w_grant_alu | w_grant_lsu;
      if (w_grant_alu) begin
        last_grant_d = GRANT_ALU;
        cdb_result_d = w_alu_head_data;
        cdb_rob_id_d = w_alu_head_tag;
      end else if (w_grant_lsu) begin
        last_grant_d = GRANT_LSU;
        cdb_result_d = w_lsu_head_data;
        cdb_rob_id_d = w_lsu_head_tag;
      end
    end
  end

  // Arbiter and broadcast registers; reset leaves LSU as last so ALU wins first.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_grant_q <= GRANT_LSU;
      cdb_valid_q  <= 1'b0;
      cdb_result_q <= '0;
      cdb_rob_id_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_result_q <= cdb_result_d;
      cdb_rob_id_q <= cdb_rob_id_d;
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_result = cdb_result_q;
  assign cdb_rob_id = cdb_rob_id_q;

endmodule : cdb_arbiter
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Directed self-checking bench for cdb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        clr;
  logic        v_alu, v_lsu;
  logic [31:0] res_alu, res_lsu;
  logic [4:0]  id_alu, id_lsu;
  logic        rdy_alu, rdy_lsu;
  logic        cdb_v;
  logic [31:0] cdb_res;
  logic [4:0]  cdb_id;

  int n_cmp = 0;
  int n_err = 0;

  cdb_arbiter dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .rdy_in          (rdy),
    .clr_in          (clr),
    .valid_from_alu  (v_alu),
    .result_from_alu (res_alu),
    .rob_id_from_alu (id_alu),
    .valid_from_lsu  (v_lsu),
    .result_from_lsu (res_lsu),
    .rob_id_from_lsu (id_lsu),
    .ready_to_alu    (rdy_alu),
    .ready_to_lsu    (rdy_lsu),
    .cdb_valid       (cdb_v),
    .cdb_result      (cdb_res),
    .cdb_rob_id      (cdb_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    v_alu = 1'b0; res_alu = '0; id_alu = '0;
    v_lsu = 1'b0; res_lsu = '0; id_lsu = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int  alu_next, lsu_next;
    logic r_alu, r_lsu, saw_lsu_block;
    int  alu_seen[$];
    int  lsu_seen[$];

    rdy = 1'b1; clr = 1'b0;
    idle_inputs();
    do_reset();

    // Reset state
    check("rst_valid",  32'(cdb_v),   32'd0);
    check("rst_result", cdb_res,      32'd0);
    check("rst_robid",  32'(cdb_id),  32'd0);
    check("rst_rdy_alu", 32'(rdy_alu), 32'd1);
    check("rst_rdy_lsu", 32'(rdy_lsu), 32'd1);

    // Single ALU result: two-edge latency, one-cycle pulse
    v_alu = 1'b1; id_alu = 5'd3; res_alu = 32'h11;
    tick();
    idle_inputs();
    check("single_e1_valid", 32'(cdb_v), 32'd0);
    tick();
    check("single_e2_valid", 32'(cdb_v), 32'd1);
    check("single_e2_id",    32'(cdb_id), 32'd3);
    check("single_e2_res",   cdb_res, 32'h11);
    tick();
    check("single_e3_valid", 32'(cdb_v), 32'd0);
    check("single_e3_hold",  cdb_res, 32'h11);

    // Flush: last grant is ALU, so LSU 20 wins while ALU 6,7 queue up
    v_alu = 1'b1; id_alu = 5'd6; res_alu = 32'h66;
    v_lsu = 1'b1; id_lsu = 5'd20; res_lsu = 32'h20;
    tick();
    v_lsu = 1'b0;
    id_alu = 5'd7; res_alu = 32'h77;
    tick();
    idle_inputs();
    check("flush_pre_id",  32'(cdb_id), 32'd20);
    check("flush_pre_rdy", 32'(rdy_alu), 32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("flush_valid", 32'(cdb_v), 32'd0);
    check("flush_rdy",   32'(rdy_alu), 32'd1);
    tick();
    check("flush_after_valid", 32'(cdb_v), 32'd0);
    tick();
    check("flush_after2_valid", 32'(cdb_v), 32'd0);

    // Stall: rob 9 pending, rob 10 queued, LSU offer during stall ignored
    v_alu = 1'b1; id_alu = 5'd9; res_alu = 32'h99;
    tick();
    id_alu = 5'd10; res_alu = 32'hA0;
    tick();
    idle_inputs();
    check("stall_pre_id", 32'(cdb_id), 32'd9);
    rdy = 1'b0;
    v_lsu = 1'b1; id_lsu = 5'd21; res_lsu = 32'h21;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 32'(cdb_v), 32'd1);
      check("stall_id",    32'(cdb_id), 32'd9);
    end
    rdy = 1'b1;
    idle_inputs();
    tick();
    check("resume_valid", 32'(cdb_v), 32'd1);
    check("resume_id",    32'(cdb_id), 32'd10);
    tick();
    check("resume_empty", 32'(cdb_v), 32'd0);

    // Contention right after reset: ALU first, then LSU
    do_reset();
    v_alu = 1'b1; id_alu = 5'd4; res_alu = 32'hA;
    v_lsu = 1'b1; id_lsu = 5'd5; res_lsu = 32'hB;
    tick();
    idle_inputs();
    tick();
    check("cont_1_id",  32'(cdb_id), 32'd4);
    check("cont_1_res", cdb_res, 32'hA);
    tick();
    check("cont_2_valid", 32'(cdb_v), 32'd1);
    check("cont_2_id",    32'(cdb_id), 32'd5);
    check("cont_2_res",   cdb_res, 32'hB);
    tick();
    check("cont_3_valid", 32'(cdb_v), 32'd0);

    // Backpressure: both sources stream, LSU tags 1..6, ALU tags 10..15
    alu_next = 10; lsu_next = 1; saw_lsu_block = 1'b0;
    for (int c = 0; c < 30; c++) begin
      v_alu = (alu_next <= 15); id_alu = 5'(alu_next); res_alu = 32'(alu_next) + 32'h100;
      v_lsu = (lsu_next <= 6);  id_lsu = 5'(lsu_next); res_lsu = 32'(lsu_next) + 32'h200;
      r_alu = rdy_alu;
      r_lsu = rdy_lsu;
      if (!r_lsu && v_lsu) saw_lsu_block = 1'b1;
      tick();
      if (v_alu && r_alu) alu_next++;
      if (v_lsu && r_lsu) lsu_next++;
      if (cdb_v) begin
        if (cdb_id >= 5'd10) begin
          alu_seen.push_back(int'(cdb_id));
          check("bp_alu_res", cdb_res, 32'(cdb_id) + 32'h100);
        end else begin
          lsu_seen.push_back(int'(cdb_id));
          check("bp_lsu_res", cdb_res, 32'(cdb_id) + 32'h200);
        end
      end
    end
    idle_inputs();
    check("bp_lsu_blocked", 32'(saw_lsu_block), 32'd1);
    check("bp_lsu_count", 32'(lsu_seen.size()), 32'd6);
    check("bp_alu_count", 32'(alu_seen.size()), 32'd6);
    for (int i = 0; i < lsu_seen.size(); i++)
      check("bp_lsu_order", 32'(lsu_seen[i]), 32'(i + 1));
    for (int i = 0; i < alu_seen.size(); i++)
      check("bp_alu_order", 32'(alu_seen[i]), 32'(i + 10));

    // Tag-0 offer is never broadcast
    v_alu = 1'b1; id_alu = 5'd0; res_alu = 32'h55;
    tick();
    idle_inputs();
    tick();
    check("tag0_e2_valid", 32'(cdb_v), 32'd0);
    tick();
    check("tag0_e3_valid", 32'(cdb_v), 32'd0);

    // Async reset between edges while rob 12 is on the bus and 13 queued
    v_alu = 1'b1; id_alu = 5'd12; res_alu = 32'hC;
    tick();
    id_alu = 5'd13; res_alu = 32'hD;
    tick();
    idle_inputs();
    check("ares_pre_id", 32'(cdb_id), 32'd12);
    #2 rst = 1'b1;
    #1;
    check("ares_valid",  32'(cdb_v), 32'd0);
    check("ares_id",     32'(cdb_id), 32'd0);
    check("ares_res",    cdb_res, 32'd0);
    check("ares_rdy_alu", 32'(rdy_alu), 32'd1);
    #1 rst = 1'b0;
    tick();
    check("ares_after_valid", 32'(cdb_v), 32'd0);
    tick();
    check("ares_after2_valid", 32'(cdb_v), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_cdb_arbiter
`default_nettype wire

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, result width.
REQ-002 SHALL have parameter ROB_ID_W, default 5, ROB tag width; tag 0 reserved as "no tag".
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, per-source queue entries (power of two, >=2).
REQ-004 SHALL have port clk_in  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rdy_in  input  1  global enable; low = freeze all state.
REQ-007 SHALL have port clr_in  input  1  synchronous flush (branch mispredict).
REQ-008 SHALL have ports valid_from_alu / result_from_alu / rob_id_from_alu  input  1/DATA_W/ROB_ID_W  ALU result offer.
REQ-009 SHALL have ports valid_from_lsu / result_from_lsu / rob_id_from_lsu  input  1/DATA_W/ROB_ID_W  LSU result offer.
REQ-010 SHALL have ports ready_to_alu, ready_to_lsu  output  1 each  source may present a result this cycle.
REQ-011 SHALL have ports cdb_valid / cdb_result / cdb_rob_id  output  1/DATA_W/ROB_ID_W  registered broadcast to RS, ROB, LSB.

Function
REQ-012 SHALL accept a source result at an edge iff rdy_in=1, clr_in=0, valid=1, ready=1 and rob_id!=0; otherwise no enqueue.
REQ-013 SHALL drive ready_to_x = (count_x < FIFO_DEPTH) from registered state only; no same-edge pass-through when full.
REQ-014 SHALL queue each source in FIFO order; one push and one pop on the same edge SHALL leave count unchanged.
REQ-015 SHALL, at each enabled edge, select at most one non-empty queue head, pop it and load cdb_* with it, cdb_valid=1.
REQ-016 SHALL, when both heads are non-empty, grant the source not granted last (round-robin via 1-bit last_grant); after reset ALU has priority.
REQ-017 SHALL update last_grant only on an actual grant; a lone non-empty source SHALL be granted regardless of last_grant.
REQ-018 SHALL drive cdb_valid=0 after an enabled edge with both queues empty; cdb_result/cdb_rob_id then hold prior values.
REQ-019 SHALL have latency exactly 2 edges from acceptance to cdb_valid when the queue was empty and uncontended.
REQ-020 SHALL keep cdb_valid a single-cycle pulse per granted entry; each accepted entry broadcast exactly once.
REQ-021 SHALL, on clr_in=1 with rdy_in=1, empty both queues, clear cdb_valid, keep last_grant, ignore inputs that edge.
REQ-022 SHALL, with rdy_in=0, hold all registers including cdb_* (a pending pulse stays visible).
REQ-023 SHALL use priority rst_in > clr_in > rdy_in=0 > normal operation.
REQ-024 SHALL sustain one broadcast per cycle total; with both sources streaming each SHALL get alternate cycles.

Reset
REQ-025 SHALL on rst_in assertion immediately clear both queues (pointers, counts), last_grant=LSU (so ALU wins first), cdb_valid=0, cdb_result=0, cdb_rob_id=0.
REQ-026 SHALL present ready_to_alu=ready_to_lsu=1 while and after reset.
REQ-027 SHALL accept nothing on the first edge coincident with rst_in deassertion only if rst_in is still high at that edge.

Structure
REQ-028 SHALL take DATA_W, ROB_ID_W and the reserved tag value 0 from the shared CPU definitions package used by RS/ROB/LSB.
REQ-029 SHALL instantiate one sub-module cdb_fifo (depth FIFO_DEPTH, push/pop/clr, count, head outputs) twice, ALU and LSU.
REQ-030 SHALL contain the arbiter, last_grant and cdb output registers at top level; no other hierarchy.

Verification
REQ-031 SHALL test single ALU result: rob_id=3, result=0x11 at edge 1 -> cdb_valid=1, rob_id=3, result=0x11 after edge 2, cdb_valid=0 after edge 3.
REQ-032 SHALL test contention: ALU (rob 4, 0xA) and LSU (rob 5, 0xB) same edge after reset -> broadcasts rob 4 then rob 5 on consecutive cycles.
REQ-033 SHALL test backpressure: LSU streams tags 1..6 every cycle with ALU streaming too -> ready_to_lsu drops when count=2, all six tags broadcast once, in order.
REQ-034 SHALL test flush: queue ALU tags 6,7, assert clr_in one cycle -> no broadcast of 6 or 7, ready_to_alu=1, cdb_valid=0 next cycle.
REQ-035 SHALL test stall: pending broadcast rob 9, hold rdy_in=0 three cycles -> cdb_valid stays 1 with rob 9, no pops, no pushes; resumes after.
REQ-036 SHALL test tag-0 drop and async reset mid-stream: rob_id=0 offer never broadcast; rst_in pulsed between edges clears cdb_valid without a clock edge.
